regs_access_arb: RTL and testbench
==================================

REGS_ACCESS_ARB -- requirements
Module: regs_access_arb

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, sets the number of core-busy pending cycles before a debug write forces a core stall.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 core_we_i / core_waddr_i / core_wdata_i  input  1/5/32  writeback request from ex.
REQ-005 dbg_req_i / dbg_we_i / dbg_addr_i / dbg_wdata_i  input  1/1/5/32  debug access request (we=1 write, we=0 read).
REQ-006 dbg_ack_o  output  1  four-phase handshake acknowledge.
REQ-007 dbg_rdata_o  output  32  debug read result, registered.
REQ-008 rf_we_o / rf_waddr_o / rf_wdata_o  output  1/5/32  arbitrated register-file write port.
REQ-009 rf_jaddr_o  output  5  register-file debug read address; rf_jdata_i  input  32  its read data.
REQ-010 core_stall_o  output  1  freezes core writeback so a starved debug write can complete.

Function
REQ-011 The FSM SHALL have states IDLE, PEND and ACK.
REQ-012 IDLE: dbg_req_i=1 SHALL latch dbg_we_i/addr/wdata and move to PEND next cycle; dbg_req_i=0 stays in IDLE.
REQ-013 PEND, read: SHALL be granted in the first PEND cycle regardless of core activity; rf_jaddr_o=latched addr; dbg_rdata_o<=rf_jdata_i, or 0 for x0; next state ACK.
REQ-014 PEND, write: grant SHALL occur in a cycle where core_we_i=0 or core_stall_o=1; in that cycle rf_we_o/waddr/wdata carry the debug write combinationally; next state ACK.
REQ-015 A debug write to x0 SHALL be granted and acknowledged with rf_we_o=0.
REQ-016 When no debug write is granted, rf_we_o/waddr/wdata SHALL pass core_we_i/waddr/wdata through combinationally; core keeps priority.
REQ-017 ACK: dbg_ack_o=1 SHALL hold until dbg_req_i=0, then return to IDLE with dbg_ack_o=0 the same cycle the state is IDLE.
REQ-018 A new request SHALL NOT be accepted until IDLE has been re-entered (a minimum of one IDLE cycle between transactions).
REQ-019 Latched request fields SHALL ignore dbg_* changes after IDLE capture.
REQ-020 Minimum latency: req rises at cycle 0 -> PEND cycle 1 -> dbg_ack_o=1 at cycle 2.
REQ-021 rf_jaddr_o SHALL be 0 outside PEND.

Reset
REQ-022 On rst=1: state IDLE, dbg_ack_o=0, dbg_rdata_o=0, core_stall_o=0, starve counter 0, latched fields 0, effective at the next clk edge, including mid-transaction.
REQ-023 During reset the write port SHALL pass core signals through unchanged (regfile gates its own writes by rst).

Configuration
REQ-024 Macro REGS_ARB_STARVE_EN: when defined, a counter SHALL increment each PEND-write cycle with core_we_i=1, and on reaching STARVE_LIMIT core_stall_o SHALL be registered high; when stall is high the debug write is granted, core_we_i is ignored that cycle, and stall and counter clear on exit from PEND.
REQ-025 Without REGS_ARB_STARVE_EN: no counter, core_stall_o tied 0, and a debug write waits indefinitely for core_we_i=0.

Structure
REQ-026 State encoding and the widths RegBus(32) and RegAddrBus(5) SHALL come from the shared defines.v; the default STARVE_LIMIT constant SHALL also live there.
REQ-027 A single sub-module regs_arb_starve (counter plus stall flop) is natural and is instantiated only under REGS_ARB_STARVE_EN.
REQ-028 The block instantiates beside regs and drives its write port and debug read port.

Verification
REQ-029 Debug write with the core idle: req, we=1, addr=5, wdata=0xDEADBEEF at cycle 0 -> rf_we_o=1 with waddr=5 at cycle 1, ack at cycle 2; a read of x5 then returns 0xDEADBEEF.
REQ-030 Debug read: x7 preloaded with 0x12345678, req we=0 addr=7 -> dbg_rdata_o=0x12345678 with ack at cycle 2, also while core_we_i=1 continuously.
REQ-031 Core collision: core_we_i=1 for cycles 1-3, debug write pending -> core writes pass, debug write granted at cycle 4, ack at cycle 5.
REQ-032 Starvation (EN defined, limit 8): core_we_i stuck at 1 -> core_stall_o=1 after 8 busy PEND cycles, debug write granted, stall 0 after ack.
REQ-033 Debug write to x0 with wdata=0xFFFFFFFF -> ack asserted, rf_we_o stays 0, x0 reads 0.
REQ-034 rst pulsed while in ACK with req held -> dbg_ack_o=0, IDLE; a held req is re-captured one cycle after rst drops.

Source files
------------

// File: rtl/regs_access_arb_pkg.sv
// Shared types for the register-file access arbiter: bus widths, FSM encoding
// and the default starvation limit.
package regs_access_arb_pkg;

   localparam int REG_BUS          = 32;
   localparam int REG_ADDR_BUS     = 5;
   localparam int STARVE_LIMIT_DEF = 8;

   typedef logic [REG_BUS-1:0]      reg_bus_t;
   typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_ACK  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/regs_access_arb_starve.sv
// Starvation guard for pending debug writes: counts core-busy PEND cycles and
// raises a registered stall once the limit is reached.
module regs_arb_starve #(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic busy_i,
   input  logic clr_i,
   output logic stall_o
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stall_q, stall_d;

   always_comb begin
      cnt_d   = cnt_q;
      stall_d = stall_q;
      if (clr_i) begin
         cnt_d   = '0;
         stall_d = 1'b0;
      end else if (busy_i && !stall_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CW'(LIMIT)) stall_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         stall_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign stall_o = stall_q;

endmodule

// File: rtl/regs_access_arb.sv
// Arbitrates the register-file write port between core writeback and a debug
// four-phase access. Define REGS_ARB_STARVE_EN to stall the core for starved debug writes.
//
//   state | meaning
//   IDLE  | waiting for dbg_req_i, captures the request fields
//   PEND  | read granted at once; write waits for an idle core or stall
//   ACK   | dbg_ack_o high until dbg_req_i drops
module regs_access_arb
   import regs_access_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      core_we_i,
   input  reg_addr_t core_waddr_i,
   input  reg_bus_t  core_wdata_i,
   input  logic      dbg_req_i,
   input  logic      dbg_we_i,
   input  reg_addr_t dbg_addr_i,
   input  reg_bus_t  dbg_wdata_i,
   output logic      dbg_ack_o,
   output reg_bus_t  dbg_rdata_o,
   output logic      rf_we_o,
   output reg_addr_t rf_waddr_o,
   output reg_bus_t  rf_wdata_o,
   output reg_addr_t rf_jaddr_o,
   input  reg_bus_t  rf_jdata_i,
   output logic      core_stall_o
);

   if (STARVE_LIMIT < 1) begin : g_bad_limit
      $error("STARVE_LIMIT must be at least 1");
   end

   arb_state_e state_q, state_d;
   logic       we_q, we_d;
   reg_addr_t  addr_q, addr_d;
   reg_bus_t   wdata_q, wdata_d;
   reg_bus_t   rdata_q, rdata_d;
   logic       stall;
   logic       grant_wr;
   logic       leave_pend;

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      grant_wr   = 1'b0;
      rf_jaddr_o = '0;
      case (state_q)
         ST_IDLE: begin
            if (dbg_req_i) begin
               we_d    = dbg_we_i;
               addr_d  = dbg_addr_i;
               wdata_d = dbg_wdata_i;
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (!we_q) begin
               rf_jaddr_o = addr_q;
               rdata_d    = (addr_q == '0) ? '0 : rf_jdata_i;
               state_d    = ST_ACK;
            end else if (!core_we_i || stall) begin
               // Core keeps the port while reset is held; the regfile gates itself.
               grant_wr = !rst;
               state_d  = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!dbg_req_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rf_we_o    = core_we_i;
      rf_waddr_o = core_waddr_i;
      rf_wdata_o = core_wdata_i;
      if (grant_wr) begin
         rf_we_o    = (addr_q != '0);
         rf_waddr_o = addr_q;
         rf_wdata_o = wdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign leave_pend  = (state_q == ST_PEND) && (state_d != ST_PEND);
   assign dbg_ack_o   = (state_q == ST_ACK);
   assign dbg_rdata_o = rdata_q;

`ifdef REGS_ARB_STARVE_EN
   regs_arb_starve #(
      .LIMIT   (STARVE_LIMIT)
   ) u_starve (
      .clk     (clk),
      .rst     (rst),
      .busy_i  ((state_q == ST_PEND) && we_q && core_we_i),
      .clr_i   (leave_pend),
      .stall_o (stall)
   );
`else
   assign stall = 1'b0;
`endif

   assign core_stall_o = stall;

endmodule

// File: tb/tb_regs_access_arb.sv
// Randomized self-checking bench for regs_access_arb with a transaction-level
// reference of the register file and grant timing.
module tb_regs_access_arb;
   import regs_access_arb_pkg::*;

   localparam int LIMIT = 8;
`ifdef REGS_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic      clk = 1'b0;
   logic      rst;
   logic      core_we_i;
   reg_addr_t core_waddr_i;
   reg_bus_t  core_wdata_i;
   logic      dbg_req_i;
   logic      dbg_we_i;
   reg_addr_t dbg_addr_i;
   reg_bus_t  dbg_wdata_i;
   logic      dbg_ack_o;
   reg_bus_t  dbg_rdata_o;
   logic      rf_we_o;
   reg_addr_t rf_waddr_o;
   reg_bus_t  rf_wdata_o;
   reg_addr_t rf_jaddr_o;
   reg_bus_t  rf_jdata_i;
   logic      core_stall_o;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] rf_mem  [32] = '{default: '0};
   logic [31:0] ref_mem [32];

   always #5 clk = ~clk;

   regs_access_arb #(.STARVE_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .core_we_i    (core_we_i),
      .core_waddr_i (core_waddr_i),
      .core_wdata_i (core_wdata_i),
      .dbg_req_i    (dbg_req_i),
      .dbg_we_i     (dbg_we_i),
      .dbg_addr_i   (dbg_addr_i),
      .dbg_wdata_i  (dbg_wdata_i),
      .dbg_ack_o    (dbg_ack_o),
      .dbg_rdata_o  (dbg_rdata_o),
      .rf_we_o      (rf_we_o),
      .rf_waddr_o   (rf_waddr_o),
      .rf_wdata_o   (rf_wdata_o),
      .rf_jaddr_o   (rf_jaddr_o),
      .rf_jdata_i   (rf_jdata_i),
      .core_stall_o (core_stall_o)
   );

   // Register file stand-in; x0 holds garbage so the arbiter must zero x0 reads itself.
   assign rf_jdata_i = rf_mem[rf_jaddr_o];
   always @(posedge clk) begin
      if (rst) rf_mem[0] <= 32'hBAD0_0BAD;
      else if (rf_we_o) rf_mem[rf_waddr_o] <= rf_wdata_o;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic drive_core(input bit busy);
      core_we_i    = busy;
      core_waddr_i = reg_addr_t'($urandom_range(1, 31));
      core_wdata_i = $urandom;
   endtask

   task automatic scramble_dbg();
      dbg_we_i    = 1'($urandom);
      dbg_addr_i  = reg_addr_t'($urandom);
      dbg_wdata_i = $urandom;
   endtask

   // Checks the write port for the current cycle and commits the expected write.
   task automatic check_port(input string tag, input bit grant, input reg_addr_t a,
                             input reg_bus_t d);
      if (grant) begin
         chk({tag, "_we"}, rf_we_o, (a != 0));
         if (a != 0) begin
            chk({tag, "_waddr"}, rf_waddr_o, a);
            chk({tag, "_wdata"}, rf_wdata_o, d);
            ref_mem[a] = d;
         end
      end else begin
         chk({tag, "_core_we"}, rf_we_o, core_we_i);
         if (core_we_i) begin
            chk({tag, "_core_waddr"}, rf_waddr_o, core_waddr_i);
            chk({tag, "_core_wdata"}, rf_wdata_o, core_wdata_i);
            if (!rst) ref_mem[core_waddr_i] = core_wdata_i;
         end
      end
   endtask

   // One full debug transaction. busy: core-busy PEND cycles before the core
   // goes idle (writes) or nonzero for a permanently busy core (reads).
   task automatic txn(input bit we, input reg_addr_t a, input reg_bus_t d,
                      input int busy, input int hold);
      int          g;
      bit          stl;
      bit          cb;
      logic [31:0] exp_rd;
      g   = we ? ((STARVE && busy >= LIMIT) ? LIMIT + 1 : busy + 1) : 1;
      stl = we && STARVE && (busy >= LIMIT);

      @(posedge clk); #1;
      dbg_req_i   = 1'b1;
      dbg_we_i    = we;
      dbg_addr_i  = a;
      dbg_wdata_i = d;
      drive_core(1'($urandom_range(0, 1)));
      @(negedge clk);
      chk("ack_c0", dbg_ack_o, 0);
      check_port("port_c0", 0, a, d);
      exp_rd = (a == 0) ? 32'h0 : ref_mem[a];

      for (int c = 1; c <= g; c++) begin
         @(posedge clk); #1;
         scramble_dbg();
         if (we) cb = (c <= busy);
         else    cb = (busy > 0) ? 1'b1 : 1'($urandom_range(0, 1));
         drive_core(cb);
         @(negedge clk);
         chk("ack_pend", dbg_ack_o, 0);
         chk("stall_pend", core_stall_o, (stl && c == g));
         if (!we) chk("jaddr_pend", rf_jaddr_o, a);
         check_port("port_pend", (we && c == g), a, d);
      end

      for (int h = 0; h <= hold; h++) begin
         @(posedge clk); #1;
         dbg_req_i = (h < hold);
         scramble_dbg();
         drive_core(1'($urandom_range(0, 1)));
         @(negedge clk);
         chk("ack_hold", dbg_ack_o, 1);
         chk("stall_ack", core_stall_o, 0);
         chk("jaddr_ack", rf_jaddr_o, 0);
         if (!we) chk("rdata", dbg_rdata_o, exp_rd);
         check_port("port_ack", 0, a, d);
      end

      @(posedge clk); #1;
      dbg_req_i = 1'b0;
      drive_core(1'($urandom_range(0, 1)));
      @(negedge clk);
      chk("ack_idle", dbg_ack_o, 0);
      check_port("port_idle", 0, a, d);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      rst = 1'b1;
      dbg_req_i = 1'b0;
      dbg_we_i = 1'b0;
      dbg_addr_i = '0;
      dbg_wdata_i = '0;
      drive_core(1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", dbg_ack_o, 0);
      chk("rst_rdata", dbg_rdata_o, 0);
      chk("rst_stall", core_stall_o, 0);
      chk("rst_jaddr", rf_jaddr_o, 0);
      check_port("rst_port", 0, '0, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed scenarios
      txn(1'b1, 5'd5, 32'hDEADBEEF, 0, 0);
      txn(1'b0, 5'd5, 32'h0, 0, 0);
      txn(1'b1, 5'd7, 32'h12345678, 0, 0);
      txn(1'b0, 5'd7, 32'h0, 1, 2);
      txn(1'b1, 5'd12, $urandom, 3, 0);
      txn(1'b1, 5'd0, 32'hFFFFFFFF, 0, 1);
      txn(1'b0, 5'd0, 32'h0, 1, 0);
      txn(1'b1, 5'd20, $urandom, 12, 1);
      txn(1'b0, 5'd20, 32'h0, 0, 0);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         bit we;
         we = 1'($urandom);
         txn(we, reg_addr_t'($urandom), $urandom,
             we ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
      end

      // Reset while a write is pending with the core idle: core must own the port.
      @(posedge clk); #1;
      dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'hA5A5_5A5A;
      drive_core(1'b0);
      @(negedge clk);
      check_port("pr_c0", 0, '0, '0);
      @(posedge clk); #1;
      rst = 1'b1;
      drive_core(1'b0);
      @(negedge clk);
      check_port("pr_rst", 0, '0, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      dbg_req_i = 1'b0;
      @(negedge clk);
      chk("pr_ack", dbg_ack_o, 0);
      chk("pr_rdata", dbg_rdata_o, 0);
      chk("pr_stall", core_stall_o, 0);
      txn(1'b0, 5'd9, 32'h0, 0, 0);

      // Reset in ACK with the request held: re-captured one cycle after rst drops.
      @(posedge clk); #1;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd7; dbg_wdata_i = '0;
      drive_core(1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("ra_ack_before", dbg_ack_o, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ra_ack_after", dbg_ack_o, 0);
      chk("ra_rdata_after", dbg_rdata_o, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ra_ack_pend", dbg_ack_o, 0);
      chk("ra_jaddr_pend", rf_jaddr_o, 7);
      @(posedge clk); #1;
      dbg_req_i = 1'b0;
      @(negedge clk);
      chk("ra_ack_recap", dbg_ack_o, 1);
      chk("ra_rdata_recap", dbg_rdata_o, ref_mem[7]);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ra_ack_done", dbg_ack_o, 0);

      // Final sweep of register contents through debug reads
      for (int r = 0; r < 32; r += 3) txn(1'b0, reg_addr_t'(r), 32'h0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
